// File: rtl/ctrl_seq_gen2.sv
// Instruction sequencer: fetch/decode FSM driving ALU, multicycle unit, register-file and PC strobes.
// Interrupt entry takes one FETCH cycle; the multicycle wait is bounded by MC_TIMEOUT and faults to HALT.
module ctrl_seq_gen2 #(
    parameter int DATA_W     = 16,
    parameter int RA_W       = 4,
    parameter int N_IRQ      = 4,
    parameter int MC_TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [DATA_W-1:0]        instr,
    output logic [RA_W-1:0]          ra_addr,
    output logic [RA_W-1:0]          rb_addr,
    output logic [RA_W-1:0]          rc_addr,
    output logic [3:0]               alu_op,
    output logic                     alu_start,
    output logic                     mc_start,
    input  logic                     mc_done,
    output logic [DATA_W-1:0]        imm,
    output logic                     wb_sel,
    output logic                     rf_we,
    output logic                     pc_inc,
    output logic                     pc_load,
    output logic                     pc_restore,
    input  logic [2:0]               flags,
    input  logic [N_IRQ-1:0]         irq,
    output logic [N_IRQ-1:0]         irq_ack,
    output logic [$clog2(N_IRQ)-1:0] vec_sel,
    output logic                     halted,
    output logic                     err_timeout
);
    localparam int VS_W  = $clog2(N_IRQ);
    localparam int CNT_W = (MC_TIMEOUT < 1) ? 1 : $clog2(MC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MC_WAIT,
        S_WB,
        S_HALT
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   instr_q;
    logic                imask_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [RA_W-1:0]     ra_q, rb_q, rc_q;
    logic [3:0]          alu_op_q;
    logic [DATA_W-1:0]   imm_q;
    logic                wb_sel_q;
    logic                alu_start_q, mc_start_q, rf_we_q;
    logic                pc_inc_q, pc_load_q, pc_restore_q;
    logic [N_IRQ-1:0]    irq_ack_q;
    logic [VS_W-1:0]     vec_sel_q;
    logic                halted_q, err_timeout_q;

    logic [3:0]          dec_op;
    logic [RA_W-1:0]     dec_ra, dec_rb, dec_rc;
    logic                irq_take;
    logic [VS_W-1:0]     irq_idx_d;
    logic                jmp_taken;
    logic                unused_gt_valid;

    assign dec_op = instr_q[DATA_W-1 -: 4];
    assign dec_ra = instr_q[DATA_W-5 -: RA_W];
    assign dec_rb = instr_q[DATA_W-5-RA_W -: RA_W];
    assign dec_rc = instr_q[DATA_W-5-2*RA_W -: RA_W];

    // rb[2:0] is a condition mask over {gt, !gt, eq}
    assign jmp_taken = (dec_rb[0] & flags[0]) | (dec_rb[1] & ~flags[1]) | (dec_rb[2] & flags[1]);
    assign unused_gt_valid = flags[2];

    assign irq_take    = (state_q == S_FETCH) && !imask_q && (|irq);
    assign instr_ready = rst_n && (state_q == S_FETCH) && !irq_take;

    always_comb begin
        irq_idx_d = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) irq_idx_d = VS_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            instr_q       <= '0;
            imask_q       <= 1'b0;
            cnt_q         <= '0;
            ra_q          <= '0;
            rb_q          <= '0;
            rc_q          <= '0;
            alu_op_q      <= '0;
            imm_q         <= '0;
            wb_sel_q      <= 1'b0;
            alu_start_q   <= 1'b0;
            mc_start_q    <= 1'b0;
            rf_we_q       <= 1'b0;
            pc_inc_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_restore_q  <= 1'b0;
            irq_ack_q     <= '0;
            vec_sel_q     <= '0;
            halted_q      <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            alu_start_q  <= 1'b0;
            mc_start_q   <= 1'b0;
            rf_we_q      <= 1'b0;
            pc_inc_q     <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_restore_q <= 1'b0;
            irq_ack_q    <= '0;
            case (state_q)
                S_FETCH: begin
                    if (irq_take) begin
                        irq_ack_q <= N_IRQ'(1) << irq_idx_d;
                        vec_sel_q <= irq_idx_d;
                        pc_load_q <= 1'b1;
                        imask_q   <= 1'b1;
                    end else if (instr_valid) begin
                        instr_q  <= instr;
                        pc_inc_q <= 1'b1;
                        state_q  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ra_q     <= dec_ra;
                    rb_q     <= dec_rb;
                    rc_q     <= dec_rc;
                    alu_op_q <= dec_op;
                    imm_q    <= DATA_W'(instr_q[DATA_W-5:RA_W]);
                    wb_sel_q <= (dec_op == 4'hB);
                    case (dec_op)
                        4'h0: state_q <= S_FETCH;
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                            alu_start_q <= 1'b1;
                            state_q     <= S_WB;
                        end
                        4'h8, 4'h9, 4'hA: begin
                            mc_start_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= S_MC_WAIT;
                        end
                        4'hB: state_q <= S_WB;
                        4'hC: begin
                            pc_load_q <= jmp_taken;
                            state_q   <= S_FETCH;
                        end
                        4'hD: begin
                            pc_restore_q <= 1'b1;
                            imask_q      <= 1'b0;
                            state_q      <= S_FETCH;
                        end
                        default: begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                    endcase
                end
                S_MC_WAIT: begin
                    // done wins over timeout when both land in the same cycle
                    if (mc_done) begin
                        state_q <= S_WB;
                    end else if (cnt_q == CNT_W'(MC_TIMEOUT)) begin
                        err_timeout_q <= 1'b1;
                        halted_q      <= 1'b1;
                        state_q       <= S_HALT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WB: begin
                    rf_we_q <= 1'b1;
                    state_q <= S_FETCH;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign ra_addr     = ra_q;
    assign rb_addr     = rb_q;
    assign rc_addr     = rc_q;
    assign alu_op      = alu_op_q;
    assign alu_start   = alu_start_q;
    assign mc_start    = mc_start_q;
    assign imm         = imm_q;
    assign wb_sel      = wb_sel_q;
    assign rf_we       = rf_we_q;
    assign pc_inc      = pc_inc_q;
    assign pc_load     = pc_load_q;
    assign pc_restore  = pc_restore_q;
    assign irq_ack     = irq_ack_q;
    assign vec_sel     = vec_sel_q;
    assign halted      = halted_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ctrl_seq_gen2.sv
// Directed bench for ctrl_seq_gen2 with hand-computed expectations.
module tb_ctrl_seq_gen2;
    localparam int DATA_W = 16;
    localparam int RA_W   = 4;
    localparam int N_IRQ  = 4;

    logic              clk;
    logic              rst_n;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [RA_W-1:0]   ra_addr, rb_addr, rc_addr;
    logic [3:0]        alu_op;
    logic              alu_start, mc_start, mc_done;
    logic [DATA_W-1:0] imm;
    logic              wb_sel, rf_we, pc_inc, pc_load, pc_restore;
    logic [2:0]        flags;
    logic [N_IRQ-1:0]  irq, irq_ack;
    logic [1:0]        vec_sel;
    logic              halted, err_timeout;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic we_seen;

    ctrl_seq_gen2 #(.DATA_W(DATA_W), .RA_W(RA_W), .N_IRQ(N_IRQ), .MC_TIMEOUT(63)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
        .alu_op(alu_op), .alu_start(alu_start), .mc_start(mc_start), .mc_done(mc_done),
        .imm(imm), .wb_sel(wb_sel), .rf_we(rf_we), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_restore(pc_restore), .flags(flags), .irq(irq), .irq_ack(irq_ack),
        .vec_sel(vec_sel), .halted(halted), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic accept(input logic [DATA_W-1:0] w);
        instr       = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; mc_done = 1'b0;
        flags = 3'b000; irq = '0; we_seen = 1'b0;
        step(); step();
        check("rst_ready", instr_ready, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err_timeout, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_pc_load", pc_load, 0);
        rst_n = 1'b1; #1;
        check("ready_after_rst", instr_ready, 1);

        // ADD r1,r2 -> r3
        instr = 16'h1123; instr_valid = 1'b1; #1;
        check("add_ready_pre", instr_ready, 1);
        step(); instr_valid = 1'b0;
        check("add_pc_inc", pc_inc, 1);
        check("add_ready_low", instr_ready, 0);
        check("add_no_early_alu", alu_start, 0);
        step();
        check("add_alu_start", alu_start, 1);
        check("add_ra", ra_addr, 1);
        check("add_rb", rb_addr, 2);
        check("add_rc", rc_addr, 3);
        check("add_alu_op", alu_op, 1);
        check("add_wb_sel", wb_sel, 0);
        check("add_no_early_we", rf_we, 0);
        step();
        check("add_rf_we", rf_we, 1);
        check("add_alu_pulse", alu_start, 0);
        check("add_ready_again", instr_ready, 1);
        step();
        check("add_we_pulse", rf_we, 0);

        // LDI: imm = instr[11:4]
        accept(16'hB7A5); step();
        check("ldi_wb_sel", wb_sel, 1);
        check("ldi_imm", imm, 16'h007A);
        check("ldi_rc", rc_addr, 5);
        check("ldi_no_alu", alu_start, 0);
        step();
        check("ldi_rf_we", rf_we, 1);

        // NOP returns to FETCH straight from DECODE
        accept(16'h0000); step();
        check("nop_ready", instr_ready, 1);
        check("nop_no_we", rf_we, 0);

        // DIV with mc_done a few cycles after mc_start
        accept(16'h9456); step();
        check("div_mc_start", mc_start, 1);
        check("div_rc", rc_addr, 6);
        check("div_alu_op", alu_op, 9);
        step();
        check("div_mc_pulse", mc_start, 0);
        we_seen = rf_we;
        repeat (3) begin step(); we_seen |= rf_we; end
        mc_done = 1'b1;
        step(); mc_done = 1'b0;
        we_seen |= rf_we;
        check("div_no_early_we", we_seen, 0);
        step();
        check("div_rf_we", rf_we, 1);
        check("div_no_err", err_timeout, 0);

        // IRQ beats a simultaneous instruction
        step();
        instr = 16'h1123; instr_valid = 1'b1; irq = 4'b0110; #1;
        check("irq_ready_low", instr_ready, 0);
        step(); instr_valid = 1'b0; irq = 4'b0100;
        check("irq_ack1", irq_ack, 4'b0010);
        check("irq_vec1", vec_sel, 1);
        check("irq_pc_load1", pc_load, 1);
        check("irq_not_accepted", pc_inc, 0);
        #1;
        check("irq_masked_ready", instr_ready, 1);
        step();
        check("irq_ack_pulse", irq_ack, 0);
        check("irq_masked_no_load", pc_load, 0);
        accept(16'hD000); step();
        check("rit_restore", pc_restore, 1);
        check("rit_no_ack", irq_ack, 0);
        #1;
        check("rit_unmask_ready", instr_ready, 0);
        step(); irq = '0;
        check("irq_ack2", irq_ack, 4'b0100);
        check("irq_vec2", vec_sel, 2);
        check("irq_pc_load2", pc_load, 1);
        check("irq_restore_pulse", pc_restore, 0);

        // JMP condition masks
        flags = 3'b001; accept(16'hC010); step();
        check("jmp_eq_load", pc_load, 1);
        check("jmp_eq_ra", ra_addr, 0);
        check("jmp_back_fetch", instr_ready, 1);
        flags = 3'b000; accept(16'hC510); step();
        check("jmp_neq_noload", pc_load, 0);
        check("jmp_neq_ra", ra_addr, 5);
        flags = 3'b010; accept(16'hC340); step();
        check("jmp_gt_load", pc_load, 1);
        check("jmp_gt_ra", ra_addr, 3);
        flags = 3'b000;

        // DIV that never completes
        accept(16'h9456); step();
        check("to_mc_start", mc_start, 1);
        we_seen = 1'b0;
        repeat (63) begin step(); we_seen |= rf_we; end
        check("to_not_yet_halted", halted, 0);
        check("to_not_yet_err", err_timeout, 0);
        step(); we_seen |= rf_we;
        check("to_err", err_timeout, 1);
        check("to_halted", halted, 1);
        check("to_no_we", we_seen, 0);
        mc_done = 1'b1;
        step(); step();
        mc_done = 1'b0;
        check("to_late_done_no_we", rf_we, 0);
        check("to_still_halted", halted, 1);
        check("to_halt_ready", instr_ready, 0);

        // async reset in HALT
        #1 rst_n = 1'b0; #1;
        check("rst_halt_err", err_timeout, 0);
        check("rst_halt_halted", halted, 0);
        check("rst_halt_ready", instr_ready, 0);
        check("rst_halt_alu_op", alu_op, 0);
        step(); rst_n = 1'b1; #1;
        check("rst_halt_ready_after", instr_ready, 1);

        // illegal opcode
        step();
        accept(16'hF000); step();
        check("ill_halted", halted, 1);
        step();
        check("ill_ready", instr_ready, 0);
        #1 rst_n = 1'b0; #1;
        check("ill_rst_halted", halted, 0);
        step(); rst_n = 1'b1;

        // reset during DECODE suppresses all later strobes
        step();
        accept(16'h1123);
        #1 rst_n = 1'b0;
        step();
        check("midrst_no_alu", alu_start, 0);
        check("midrst_no_pc_inc", pc_inc, 0);
        rst_n = 1'b1;
        step();
        check("midrst_no_we", rf_we, 0);
        check("midrst_ready", instr_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
